// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the framed-string UART transmit arbiter.
package uart_arb_pkg;

    localparam int unsigned DEF_STR_W = 1024;
    localparam int unsigned DEF_LEN_W = 8;

    typedef enum logic [4:0] {
        StIdle    = 5'b00001,
        StArb     = 5'b00010,
        StIssue   = 5'b00100,
        StWait    = 5'b01000,
        StRelease = 5'b10000
    } state_e;

    // Pointer starts at the last requester so requester 0 wins the first scan.
    function automatic int unsigned ptr_reset(input int unsigned num_req);
        return num_req - 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating priority encoder: first set bit of req scanning ptr+1, ptr+2, ... mod NUM_REQ.
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int k;

    // Scan from the far end so the nearest candidate after ptr is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = (int'(ptr) + i) % int'(NUM_REQ);
            if (req[k]) begin
                idx   = k[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_string_arbiter.sv
// Round-robin arbiter sharing one framed-string UART transmit channel among NUM_REQ requesters.
// Optional WAIT_DONE watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_string_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned STR_W          = DEF_STR_W,
    parameter int unsigned LEN_W          = DEF_LEN_W,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*STR_W-1:0]     req_string,
    input  logic [NUM_REQ*LEN_W-1:0]     req_length,
    output logic [NUM_REQ-1:0]           req_done,
    output logic [NUM_REQ-1:0]           req_err,
    output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
    output logic                         arb_busy,
    output logic [STR_W-1:0]             tx_string,
    output logic [LEN_W-1:0]             tx_length,
    output logic                         tx_req,
    input  logic                         tx_busy,
    input  logic                         tx_done
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_string_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("uart_string_arbiter: TIMEOUT_CYCLES must be nonzero");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, grant_q;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [LEN_W-1:0] pick_len;
    logic             timeout;
    logic             err_q;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign pick_len = req_length[pick_idx*LEN_W +: LEN_W];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter is zero whenever outside WAIT_DONE, so it restarts on every entry.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == StWait) ? cnt_q + 1'b1 : '0;
            err_q <= (state_q == StWait) && !tx_done && timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr_q   <= IDX_W'(ptr_reset(NUM_REQ));
            grant_q <= '0;
        end else begin
            if (state_q == StArb && pick_found) grant_q <= pick_idx;
            if (state_q == StRelease)           ptr_q   <= grant_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (|req_valid) state_d = StArb;
            StArb: begin
                if (!pick_found)          state_d = StIdle;
                else if (pick_len == '0)  state_d = StRelease;
                else                      state_d = StIssue;
            end
            StIssue:   if (!tx_busy) state_d = StWait;
            StWait:    if (tx_done || timeout) state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        req_done = '0;
        req_err  = '0;
        if (state_q == StRelease) begin
            req_done[grant_q] = 1'b1;
            req_err[grant_q]  = err_q;
        end
        tx_req    = (state_q == StIssue) && !tx_busy;
        arb_busy  = (state_q != StIdle);
        grant_idx = grant_q;
        // Data is forced to zero while idle so every output is quiet after reset.
        tx_string = arb_busy ? req_string[grant_q*STR_W +: STR_W] : '0;
        tx_length = arb_busy ? req_length[grant_q*LEN_W +: LEN_W] : '0;
    end

endmodule
